// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcodes, ALUOp encodings, control bundle
// and small helper functions used by the ID stage.
package mips_defs;

   localparam int DW   = 32;
   localparam int NREG = 32;

   // Primary opcode field (ins[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // ALUOp encodings handed to the EX-stage ALU control
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       jump;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   // Main control table; anything not listed is flagged illegal with no side effects
   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_RTYPE;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_op     = ALUOP_ADD;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.alu_op    = ALUOP_ADD;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = ALUOP_SUB;
         end
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_ADD;
         end
         OP_ANDI, OP_ORI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALUOP_LOGIC;
         end
         OP_J: begin
            c.jump = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

   // Opcodes whose rt field is a source operand (not a destination)
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   endfunction

   // Logical immediates are zero-extended, everything else sign-extended
   function automatic logic zero_ext_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/regfile.sv
// 2-read / 1-write register file with r0 hardwired to zero, synchronous
// clear and write-through bypass so ID sees a same-cycle write-back.
module regfile #(
   parameter int NREG = 32,
   parameter int DW   = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          srst,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);

   logic [DW-1:0] regs_reg [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         // One storage word per register; r0 never accepts a write and the clear wins over write-back
         always_ff @(posedge clk) begin
            if (srst) begin
               regs_reg[gi] <= '0;
            end else if (we && (waddr != '0) && (waddr == AW'(gi))) begin
               regs_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   // rs read port: r0 reads zero, otherwise a matching write-back is forwarded
   always_comb begin
      rs_data = regs_reg[rs_addr];
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (we && (waddr == rs_addr)) begin
         rs_data = wdata;
      end
   end

   // rt read port, same forwarding rule as rs
   always_comb begin
      rt_data = regs_reg[rt_addr];
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (we && (waddr == rt_addr)) begin
         rt_data = wdata;
      end
   end

endmodule

// File: rtl/instr_decode.sv
// MIPS ID stage: IF/ID latch, main control decode, register read, immediate
// extension, branch/jump target formation and load-use stall detection.
module instr_decode #(
   parameter int NREG = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [31:0]   iins,
   input  logic [DW-1:0] ipc4,
   input  logic          iSIG_Flush,
   input  logic          iwb_en,
   input  logic [4:0]    iwb_addr,
   input  logic [DW-1:0] iwb_data,
   input  logic          iex_memread,
   input  logic [4:0]    iex_rt,
   output logic          oSIG_Stall,
   output logic          ovalid,
   output logic [DW-1:0] opc4,
   output logic [DW-1:0] ors_data,
   output logic [DW-1:0] ort_data,
   output logic [DW-1:0] oimm,
   output logic [4:0]    ors,
   output logic [4:0]    ort,
   output logic [4:0]    ord,
   output logic [DW-1:0] obranch_target,
   output logic [DW-1:0] ojump_target,
   output logic          oSIG_RegWrite,
   output logic          oSIG_MemRead,
   output logic          oSIG_MemWrite,
   output logic          oSIG_MemtoReg,
   output logic          oSIG_ALUSrc,
   output logic          oSIG_RegDst,
   output logic          oSIG_Branch,
   output logic          oSIG_Jump,
   output logic [1:0]    oSIG_ALUOp,
   output logic          oillegal
);

   import mips_defs::*;

   logic [31:0]   ins_reg;
   logic [DW-1:0] pc4_reg;
   logic          valid_reg;

   logic [5:0]    op;
   logic [4:0]    rs_f;
   logic [4:0]    rt_f;
   logic [4:0]    rd_f;
   logic [15:0]   imm16;
   logic          stall;
   logic [DW-1:0] rs_rf;
   logic [DW-1:0] rt_rf;
   logic [DW-1:0] imm_sext;
   logic [DW-1:0] imm_ext;
   ctrl_t         ctrl;

   assign op    = ins_reg[31:26];
   assign rs_f  = ins_reg[25:21];
   assign rt_f  = ins_reg[20:16];
   assign rd_f  = ins_reg[15:11];
   assign imm16 = ins_reg[15:0];

   // Load-use hazard: the load in EX writes a register this instruction reads
   assign stall = valid_reg && iex_memread && (iex_rt != 5'd0) &&
                  ((iex_rt == rs_f) || ((iex_rt == rt_f) && uses_rt(op)));

   // IF/ID latch: reset beats flush beats stall beats load; a flush keeps the old PC+4
   always_ff @(posedge clk) begin
      if (rstn) begin
         ins_reg   <= '0;
         pc4_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (iSIG_Flush) begin
         ins_reg   <= '0;
         valid_reg <= 1'b0;
      end else if (!stall) begin
         ins_reg   <= iins;
         pc4_reg   <= ipc4;
         valid_reg <= 1'b1;
      end
   end

   regfile #(
      .NREG (NREG),
      .DW   (DW)
   ) u_regfile (
      .clk     (clk),
      .srst    (rstn),
      .rs_addr (rs_f),
      .rt_addr (rt_f),
      .rs_data (rs_rf),
      .rt_data (rt_rf),
      .we      (iwb_en),
      .waddr   (iwb_addr),
      .wdata   (iwb_data)
   );

   assign imm_sext = {{(DW-16){imm16[15]}}, imm16};
   assign imm_ext  = zero_ext_imm(op) ? {{(DW-16){1'b0}}, imm16} : imm_sext;

   // Control decode, squashed to a bubble while stalled or when IF/ID is empty
   always_comb begin
      ctrl = decode_ctrl(op);
      if (!valid_reg || stall) begin
         ctrl = '0;
      end
   end

   // Output drive: everything reads zero while IF/ID holds no live instruction
   always_comb begin
      oSIG_Stall     = stall;
      ovalid         = valid_reg;
      opc4           = '0;
      ors_data       = '0;
      ort_data       = '0;
      oimm           = '0;
      ors            = '0;
      ort            = '0;
      ord            = '0;
      obranch_target = '0;
      ojump_target   = '0;
      if (valid_reg) begin
         opc4           = pc4_reg;
         ors_data       = rs_rf;
         ort_data       = rt_rf;
         oimm           = imm_ext;
         ors            = rs_f;
         ort            = rt_f;
         ord            = rd_f;
         obranch_target = pc4_reg + {imm_sext[DW-3:0], 2'b00};
         ojump_target   = {pc4_reg[31:28], ins_reg[25:0], 2'b00};
      end
      oSIG_RegWrite = ctrl.reg_write;
      oSIG_MemRead  = ctrl.mem_read;
      oSIG_MemWrite = ctrl.mem_write;
      oSIG_MemtoReg = ctrl.mem_to_reg;
      oSIG_ALUSrc   = ctrl.alu_src;
      oSIG_RegDst   = ctrl.reg_dst;
      oSIG_Branch   = ctrl.branch;
      oSIG_Jump     = ctrl.jump;
      oSIG_ALUOp    = ctrl.alu_op;
      oillegal      = ctrl.illegal;
   end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: a shadow IF/ID + register file model
// produces expected outputs that go through a scoreboard queue, plus
// directed constant checks on the documented example instructions.
module tb_instr_decode;

   typedef struct packed {
      logic        valid;
      logic        stall;
      logic [10:0] ctrl;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] btgt;
      logic [31:0] jtgt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } out_t;

   logic        clk;
   logic        rstn;
   logic [31:0] iins;
   logic [31:0] ipc4;
   logic        iSIG_Flush;
   logic        iwb_en;
   logic [4:0]  iwb_addr;
   logic [31:0] iwb_data;
   logic        iex_memread;
   logic [4:0]  iex_rt;
   logic        oSIG_Stall, ovalid;
   logic [31:0] opc4, ors_data, ort_data, oimm, obranch_target, ojump_target;
   logic [4:0]  ors, ort, ord;
   logic        oSIG_RegWrite, oSIG_MemRead, oSIG_MemWrite, oSIG_MemtoReg;
   logic        oSIG_ALUSrc, oSIG_RegDst, oSIG_Branch, oSIG_Jump, oillegal;
   logic [1:0]  oSIG_ALUOp;

   out_t        obs;
   out_t        sb_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] sh_rf [32];
   logic [31:0] sh_ins   = '0;
   logic [31:0] sh_pc4   = '0;
   logic        sh_valid = 1'b0;

   instr_decode dut (
      .clk            (clk),
      .rstn           (rstn),
      .iins           (iins),
      .ipc4           (ipc4),
      .iSIG_Flush     (iSIG_Flush),
      .iwb_en         (iwb_en),
      .iwb_addr       (iwb_addr),
      .iwb_data       (iwb_data),
      .iex_memread    (iex_memread),
      .iex_rt         (iex_rt),
      .oSIG_Stall     (oSIG_Stall),
      .ovalid         (ovalid),
      .opc4           (opc4),
      .ors_data       (ors_data),
      .ort_data       (ort_data),
      .oimm           (oimm),
      .ors            (ors),
      .ort            (ort),
      .ord            (ord),
      .obranch_target (obranch_target),
      .ojump_target   (ojump_target),
      .oSIG_RegWrite  (oSIG_RegWrite),
      .oSIG_MemRead   (oSIG_MemRead),
      .oSIG_MemWrite  (oSIG_MemWrite),
      .oSIG_MemtoReg  (oSIG_MemtoReg),
      .oSIG_ALUSrc    (oSIG_ALUSrc),
      .oSIG_RegDst    (oSIG_RegDst),
      .oSIG_Branch    (oSIG_Branch),
      .oSIG_Jump      (oSIG_Jump),
      .oSIG_ALUOp     (oSIG_ALUOp),
      .oillegal       (oillegal)
   );

   assign obs = {ovalid, oSIG_Stall, oSIG_RegWrite, oSIG_MemRead, oSIG_MemWrite,
                 oSIG_MemtoReg, oSIG_ALUSrc, oSIG_RegDst, oSIG_Branch, oSIG_Jump,
                 oSIG_ALUOp, oillegal, opc4, ors_data, ort_data, oimm,
                 obranch_target, ojump_target, ors, ort, ord};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_stall();
      logic [5:0] op;
      logic       rt_src;
      op     = sh_ins[31:26];
      rt_src = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      return sh_valid && iex_memread && (iex_rt != 5'd0) &&
             ((iex_rt == sh_ins[25:21]) || ((iex_rt == sh_ins[20:16]) && rt_src));
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (iwb_en && (iwb_addr == a)) return iwb_data;
      return sh_rf[a];
   endfunction

   // Expected outputs from the shadow state and current inputs
   function automatic out_t exp_out();
      out_t        o;
      logic [5:0]  op;
      logic [31:0] sx;
      o = '0;
      if (!sh_valid) return o;
      op        = sh_ins[31:26];
      sx        = {{16{sh_ins[15]}}, sh_ins[15:0]};
      o.valid   = 1'b1;
      o.stall   = exp_stall();
      o.pc4     = sh_pc4;
      o.rs      = sh_ins[25:21];
      o.rt      = sh_ins[20:16];
      o.rd      = sh_ins[15:11];
      o.rs_data = rf_read(o.rs);
      o.rt_data = rf_read(o.rt);
      o.imm     = (op == 6'h0C || op == 6'h0D) ? {16'h0, sh_ins[15:0]} : sx;
      o.btgt    = sh_pc4 + (sx << 2);
      o.jtgt    = {sh_pc4[31:28], sh_ins[25:0], 2'b00};
      // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,Branch,Jump,ALUOp[1:0],illegal}
      case (op)
         6'h00:        o.ctrl = 11'b1_0_0_0_0_1_0_0_10_0;
         6'h23:        o.ctrl = 11'b1_1_0_1_1_0_0_0_00_0;
         6'h2B:        o.ctrl = 11'b0_0_1_0_1_0_0_0_00_0;
         6'h04:        o.ctrl = 11'b0_0_0_0_0_0_1_0_01_0;
         6'h08:        o.ctrl = 11'b1_0_0_0_1_0_0_0_00_0;
         6'h0C, 6'h0D: o.ctrl = 11'b1_0_0_0_1_0_0_0_11_0;
         6'h02:        o.ctrl = 11'b0_0_0_0_0_0_0_1_00_0;
         default:      o.ctrl = 11'b0_0_0_0_0_0_0_0_00_1;
      endcase
      if (o.stall) o.ctrl = '0;
      return o;
   endfunction

   // One clock edge: advance the shadow model using the pre-edge inputs
   task automatic clk_edge();
      logic        st, rs_now, fl, wr;
      logic [4:0]  wa;
      logic [31:0] wd, ni, np;
      st = exp_stall();
      rs_now = rstn;
      fl = iSIG_Flush;
      wr = iwb_en && (iwb_addr != 5'd0);
      wa = iwb_addr;
      wd = iwb_data;
      ni = iins;
      np = ipc4;
      @(posedge clk);
      if (rs_now) begin
         for (int i = 0; i < 32; i++) sh_rf[i] = '0;
         sh_ins = '0; sh_pc4 = '0; sh_valid = 1'b0;
      end else begin
         if (wr) sh_rf[wa] = wd;
         if (fl) begin
            sh_ins = '0; sh_valid = 1'b0;
         end else if (!st) begin
            sh_ins = ni; sh_pc4 = np; sh_valid = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      out_t e;
      rstn = 1'b1; iins = 32'h8C220004; ipc4 = 32'h100;
      for (int c = 0; c < 2; c++) begin
         clk_edge();
         sb_q.push_back(exp_out());
         e = sb_q.pop_front();
         n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", obs, e); end
         n_tests++;
         if ({ovalid, obs.ctrl} !== 12'h000) begin
            n_fail++; $display("FAIL reset_ctrl: got valid=%b ctrl=%h want 0/000", ovalid, obs.ctrl);
         end
      end
   endtask

   task automatic test_lw();
      out_t e;
      rstn = 1'b0; iins = 32'h8C220004; ipc4 = 32'h100;
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL lw_sb: got %h want %h", obs, e); end
      n_tests++;
      if ({oSIG_MemRead, oSIG_ALUSrc, oSIG_MemtoReg, oSIG_RegWrite, oimm, obranch_target, ort}
          !== {4'b1111, 32'd4, 32'h110, 5'd2}) begin
         n_fail++; $display("FAIL lw_fields: got mr/as/m2r/rw=%b%b%b%b imm=%h bt=%h rt=%0d want 1111 4 110 2",
                            oSIG_MemRead, oSIG_ALUSrc, oSIG_MemtoReg, oSIG_RegWrite, oimm, obranch_target, ort);
      end
      n_tests++;
      if ({ors_data, ort_data} !== 64'd0) begin
         n_fail++; $display("FAIL lw_rf_zero: got rs=%h rt=%h want 0 0", ors_data, ort_data);
      end
   endtask

   task automatic test_bypass();
      out_t e;
      iins = 32'h00A01820; ipc4 = 32'h104;        // add r3,r5,r0
      clk_edge();
      iwb_en = 1'b1; iwb_addr = 5'd5; iwb_data = 32'hDEADBEEF;
      #1;
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL bypass_sb: got %h want %h", obs, e); end
      n_tests++;
      if (ors_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL bypass_rs: got %h want deadbeef", ors_data);
      end
      clk_edge();
      iwb_en = 1'b0;
      #1;
      n_tests++;
      if (ors_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL stored_rs: got %h want deadbeef", ors_data);
      end
      iwb_en = 1'b1; iwb_addr = 5'd0; iwb_data = 32'h12345678;
      #1;
      n_tests++;
      if (ort_data !== 32'd0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", ort_data); end
      clk_edge();
      iwb_en = 1'b0;
      #1;
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e || ort_data !== 32'd0) begin
         n_fail++; $display("FAIL r0_write: got %h want %h", obs, e);
      end
   endtask

   task automatic test_stall();
      out_t e;
      iins = 32'h00441820; ipc4 = 32'h200;        // add r3,r2,r4
      clk_edge();
      iex_memread = 1'b1; iex_rt = 5'd2;
      iins = 32'h2004000A; ipc4 = 32'h204;        // addi r4,r0,10 waiting in fetch
      #1;
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL stall_sb: got %h want %h", obs, e); end
      n_tests++;
      if ({oSIG_Stall, obs.ctrl, ord} !== {1'b1, 11'd0, 5'd3}) begin
         n_fail++; $display("FAIL stall_bubble: got stall=%b ctrl=%h rd=%0d want 1 000 3", oSIG_Stall, obs.ctrl, ord);
      end
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e || opc4 !== 32'h200) begin
         n_fail++; $display("FAIL stall_hold: got %h want %h", obs, e);
      end
      iex_memread = 1'b0;
      #1;
      n_tests++;
      if ({oSIG_Stall, oSIG_RegWrite, oSIG_RegDst, oSIG_ALUOp} !== 5'b01110) begin
         n_fail++; $display("FAIL stall_release: got %b want 01110", {oSIG_Stall, oSIG_RegWrite, oSIG_RegDst, oSIG_ALUOp});
      end
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e || oimm !== 32'd10) begin
         n_fail++; $display("FAIL after_stall: got %h want %h", obs, e);
      end
      // addi writes rt, so a load to r4 is no hazard; iex_rt==0 never stalls
      iex_memread = 1'b1; iex_rt = 5'd4;
      #1;
      n_tests++;
      if (oSIG_Stall !== 1'b0) begin n_fail++; $display("FAIL addi_rt_nostall: got %b want 0", oSIG_Stall); end
      iex_rt = 5'd0;
      #1;
      n_tests++;
      if (oSIG_Stall !== 1'b0) begin n_fail++; $display("FAIL rt0_nostall: got %b want 0", oSIG_Stall); end
      iex_memread = 1'b0;
   endtask

   task automatic test_flush();
      out_t e;
      iins = 32'h00441820; ipc4 = 32'h300;
      clk_edge();
      iex_memread = 1'b1; iex_rt = 5'd2; iSIG_Flush = 1'b1;
      #1;
      n_tests++;
      if (oSIG_Stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b want 1", oSIG_Stall); end
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL flush_sb: got %h want %h", obs, e); end
      n_tests++;
      if ({ovalid, oillegal, oSIG_Stall} !== 3'b000) begin
         n_fail++; $display("FAIL flush_empty: got v/ill/st=%b%b%b want 000", ovalid, oillegal, oSIG_Stall);
      end
      iSIG_Flush = 1'b0; iex_memread = 1'b0;
   endtask

   task automatic test_decode_mix();
      out_t        e;
      logic [31:0] ins_t  [7] = '{32'h3C010001, 32'h3421FFFF, 32'h30828000, 32'hAC430008,
                                  32'h1000FFFF, 32'h08000010, 32'h2001FFFF};
      logic [31:0] pc_t   [7] = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h0, 32'hA0000004, 32'h500};
      logic [31:0] imm_t  [7] = '{32'h1, 32'h0000FFFF, 32'h00008000, 32'h8,
                                  32'hFFFFFFFF, 32'h0010, 32'hFFFFFFFF};
      logic [31:0] tgt_t  [7] = '{32'h404, 32'h404 + 32'hFFFFFFFC, 32'h408 + 32'hFFFE0000, 32'h42C,
                                  32'hFFFFFFFC, 32'hA0000040, 32'h4FC};
      logic        ill_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         iins = ins_t[i]; ipc4 = pc_t[i];
         clk_edge();
         sb_q.push_back(exp_out());
         e = sb_q.pop_front();
         n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL mix%0d_sb: got %h want %h", i, obs, e); end
         n_tests++;
         if ({oimm, oillegal, (ins_t[i][31:26] == 6'h02) ? ojump_target : obranch_target}
             !== {imm_t[i], ill_t[i], tgt_t[i]}) begin
            n_fail++; $display("FAIL mix%0d_const: got imm=%h ill=%b tgt=%h/%h want %h %b %h",
                               i, oimm, oillegal, obranch_target, ojump_target, imm_t[i], ill_t[i], tgt_t[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      out_t e;
      for (int i = 0; i < 24; i++) begin
         iins = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'd3, 11'h020};
         ipc4 = 32'h600 + 32'(i * 4);
         iwb_en = 1'($urandom_range(0, 1));
         iwb_addr = 5'($urandom_range(0, 7));
         iwb_data = $urandom;
         #1;
         sb_q.push_back(exp_out());
         e = sb_q.pop_front();
         n_tests++;
         if (obs !== e) begin n_fail++; $display("FAIL b2b%0d: got %h want %h", i, obs, e); end
         clk_edge();
      end
      iwb_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_t e;
      iwb_en = 1'b1; iwb_addr = 5'd7; iwb_data = 32'h0000CAFE; rstn = 1'b1;
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e) begin n_fail++; $display("FAIL midreset_sb: got %h want %h", obs, e); end
      rstn = 1'b0; iwb_en = 1'b0;
      iins = 32'h00A71820; ipc4 = 32'h700;        // add r3,r5,r7
      clk_edge();
      sb_q.push_back(exp_out());
      e = sb_q.pop_front();
      n_tests++;
      if (obs !== e || {ors_data, ort_data} !== 64'd0) begin
         n_fail++; $display("FAIL midreset_clear: got rs=%h rt=%h want 0 0", ors_data, ort_data);
      end
   endtask

   initial begin
      rstn = 1'b1; iins = '0; ipc4 = '0; iSIG_Flush = 1'b0;
      iwb_en = 1'b0; iwb_addr = '0; iwb_data = '0;
      iex_memread = 1'b0; iex_rt = '0;
      for (int i = 0; i < 32; i++) sh_rf[i] = '0;
      test_reset();
      test_lw();
      test_bypass();
      test_stall();
      test_flush();
      test_decode_mix();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
